// File: rtl/alu_op_sequencer.sv
// Command FIFO and operand driver for escal_ALU: queues commands, holds operands on the ALU
// for SETTLE cycles, then captures result, flags and tag into a valid/ready response port.
module alu_op_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic                       cmd_cin,
    input  logic [DATA_W-1:0]          cmd_a,
    input  logic [DATA_W-1:0]          cmd_b,
    input  logic [TAG_W-1:0]           cmd_tag,
    output logic                       alu_cin,
    output logic [2:0]                 alu_op,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic [6:0]                 alu_flags,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_result,
    output logic [6:0]                 rsp_flags,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned ENT_W = 4 + 2 * DATA_W + TAG_W;

    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_e            state_q, state_d;
    logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
    logic [2:0]        op_q, op_d;
    logic              cin_q, cin_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [6:0]        rsp_flags_q, rsp_flags_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              push, pop;

    logic [2:0]        head_op;
    logic              head_cin;
    logic [DATA_W-1:0] head_a, head_b;
    logic [TAG_W-1:0]  head_tag;

    assign {head_op, head_cin, head_a, head_b, head_tag} = mem_q[rptr_q];
    assign cmd_ready = (count_q < CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q] = {cmd_op, cmd_cin, cmd_a, cmd_b, cmd_tag};
        end
        state_d      = state_q;
        set_cnt_d    = set_cnt_q;
        op_d         = op_q;
        cin_d        = cin_q;
        a_d          = a_q;
        b_d          = b_q;
        tag_d        = tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_tag_d    = rsp_tag_q;
        rptr_d       = rptr_q;
        wptr_d       = wptr_q;
        pop          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (set_cnt_q == SET_W'(SETTLE - 1)) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_tag_d    = tag_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = StResp;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = StDrive;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Operand registers only change on a pop, so the ALU inputs never glitch between commands.
        if (pop) begin
            op_d      = head_op;
            cin_d     = head_cin;
            a_d       = head_a;
            b_d       = head_b;
            tag_d     = head_tag;
            set_cnt_d = '0;
            rptr_d    = rptr_q + PTR_W'(1);
        end
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            set_cnt_q    <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            op_q         <= '0;
            cin_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            set_cnt_q    <= set_cnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            op_q         <= op_d;
            cin_q        <= cin_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign alu_op     = op_q;
    assign alu_cin    = cin_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_tag    = rsp_tag_q;
    assign count      = count_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a stand-in ALU feeds results back, and responses are checked
// against directed expectations and an in-order queue of commands accepted at the port.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cv1, cv3;
    logic [2:0]  cmd_op;
    logic        cmd_cin;
    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  cmd_tag;
    logic        rsp_ready;

    logic        cmd_ready1, alu_cin1, rsp_valid1, busy1;
    logic [2:0]  alu_op1, count1;
    logic [31:0] alu_a1, alu_b1, alu_result1, rsp_result1;
    logic [6:0]  alu_flags1, rsp_flags1;
    logic [3:0]  rsp_tag1;

    logic        cmd_ready3, alu_cin3, rsp_valid3, busy3;
    logic [2:0]  alu_op3, count3;
    logic [31:0] alu_a3, alu_b3, alu_result3, rsp_result3;
    logic [6:0]  alu_flags3, rsp_flags3;
    logic [3:0]  rsp_tag3;

    int n_chk  = 0;
    int n_fail = 0;
    int push_to = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [6:0]  fl;
        logic [3:0]  tag;
        int          cyc;
    } rsp_t;

    rsp_t got1[$];
    rsp_t exp1[$];

    always #5 clk = ~clk;

    // Stand-in escal_ALU: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 sll, 111 srl
    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        case (op)
            3'd0:    return a + b + {31'd0, cin};
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    function automatic logic [6:0] fl_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic        ovf, cy;
        s   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        r   = alu_fn(op, a, b, cin);
        ovf = 1'b0;
        cy  = 1'b0;
        if (op == 3'd0) begin
            ovf = (a[31] == b[31]) && (r[31] != a[31]);
            cy  = s[32];
        end else if (op == 3'd1) begin
            ovf = (a[31] != b[31]) && (r[31] != a[31]);
            cy  = (a < b);
        end
        return {$signed(a) < $signed(b), a == b, r[31], ovf, cy, r == 32'd0, cy};
    endfunction

    assign alu_result1 = alu_fn(alu_op1, alu_a1, alu_b1, alu_cin1);
    assign alu_flags1  = fl_fn(alu_op1, alu_a1, alu_b1, alu_cin1);
    assign alu_result3 = alu_fn(alu_op3, alu_a3, alu_b3, alu_cin3);
    assign alu_flags3  = fl_fn(alu_op3, alu_a3, alu_b3, alu_cin3);

    alu_op_sequencer #(.DATA_W(32), .DEPTH(4), .SETTLE(1), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cv1), .cmd_ready(cmd_ready1), .cmd_op(cmd_op),
        .cmd_cin(cmd_cin), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_cin(alu_cin1), .alu_op(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_result(alu_result1), .alu_flags(alu_flags1), .rsp_valid(rsp_valid1),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result1), .rsp_flags(rsp_flags1),
        .rsp_tag(rsp_tag1), .count(count1), .busy(busy1)
    );

    alu_op_sequencer #(.DATA_W(32), .DEPTH(4), .SETTLE(3), .TAG_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cv3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op),
        .cmd_cin(cmd_cin), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_cin(alu_cin3), .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_result(alu_result3), .alu_flags(alu_flags3), .rsp_valid(rsp_valid3),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result3), .rsp_flags(rsp_flags3),
        .rsp_tag(rsp_tag3), .count(count3), .busy(busy3)
    );

    // Record accepted commands (as expected responses) and completed response handshakes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (cv1 && cmd_ready1)
                exp1.push_back('{alu_fn(cmd_op, cmd_a, cmd_b, cmd_cin),
                                 fl_fn(cmd_op, cmd_a, cmd_b, cmd_cin), cmd_tag, cyc});
            if (rsp_valid1 && rsp_ready)
                got1.push_back('{rsp_result1, rsp_flags1, rsp_tag1, cyc});
        end
    end

    task automatic push1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [3:0] tag);
        int k = 0;
        while (!cmd_ready1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) push_to++;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_tag = tag;
        cv1 = 1'b1;
        @(negedge clk);
        cv1 = 1'b0;
    endtask

    task automatic wait_got1(input int n);
        int k = 0;
        while (got1.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cv1 = 1'b0; cv3 = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; cmd_tag = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({cmd_ready1, rsp_valid1, busy1, count1} !== {3'b100, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b cnt=%0d need 1 0 0 0",
                     cmd_ready1, rsp_valid1, busy1, count1);
        end
        n_chk++;
        if ({alu_op1, alu_cin1, alu_a1, alu_b1} !== '0) begin
            n_fail++;
            $display("FAIL reset_alu got op=%0d a=%0h b=%0h need 0", alu_op1, alu_a1, alu_b1);
        end
        n_chk++;
        if ({rsp_result1, rsp_flags1, rsp_tag1} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp got res=%0h fl=%0h tag=%0d need 0",
                     rsp_result1, rsp_flags1, rsp_tag1);
        end
        n_chk++;
        if ({cmd_ready3, rsp_valid3, busy3, count3} !== {3'b100, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_dut3 got rdy=%b vld=%b busy=%b cnt=%0d need 1 0 0 0",
                     cmd_ready3, rsp_valid3, busy3, count3);
        end
    endtask

    task automatic test_add;
        int lat = 0;
        int gb = got1.size();
        rsp_ready = 1'b0;
        push1(3'd0, 32'd6, 32'd2, 1'b0, 4'd3);
        while (!rsp_valid1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_chk++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL t1_latency got %0d need 2", lat);
        end
        n_chk++;
        if ({rsp_result1, rsp_tag1, rsp_flags1[1]} !== {32'd8, 4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL t1_rsp got res=%0d tag=%0d zero=%b need 8 3 0",
                     rsp_result1, rsp_tag1, rsp_flags1[1]);
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if ({rsp_valid1, rsp_result1, busy1} !== {1'b1, 32'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL t1_hold got vld=%b res=%0d busy=%b need 1 8 1",
                     rsp_valid1, rsp_result1, busy1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({rsp_valid1, busy1, got1.size() == gb + 1} !== 3'b001) begin
            n_fail++;
            $display("FAIL t1_release got vld=%b busy=%b nrsp=%0d need 0 0 %0d",
                     rsp_valid1, busy1, got1.size(), gb + 1);
        end
    endtask

    task automatic test_burst;
        logic [31:0] want [4];
        int gb = got1.size();
        want[0] = 32'd300; want[1] = 32'd10; want[2] = 32'd11; want[3] = 32'd2;
        rsp_ready = 1'b1;
        push1(3'd2, 32'd10, 32'd30, 1'b0, 4'd1);
        push1(3'd3, 32'd300, 32'd30, 1'b0, 4'd2);
        push1(3'd5, 32'd10, 32'd1, 1'b0, 4'd3);
        push1(3'd4, 32'd10, 32'd6, 1'b0, 4'd4);
        wait_got1(gb + 4);
        n_chk++;
        if (got1.size() != gb + 4) begin
            n_fail++;
            $display("FAIL t2_count got %0d need %0d", got1.size() - gb, 4);
        end
        for (int i = 0; i < 4 && gb + i < got1.size(); i++) begin
            n_chk++;
            if ({got1[gb+i].res, got1[gb+i].tag} !== {want[i], 4'(i + 1)}) begin
                n_fail++;
                $display("FAIL t2_rsp%0d got res=%0d tag=%0d need %0d %0d",
                         i, got1[gb+i].res, got1[gb+i].tag, want[i], i + 1);
            end
            if (i > 0) begin
                n_chk++;
                if (got1[gb+i].cyc - got1[gb+i-1].cyc != 2) begin
                    n_fail++;
                    $display("FAIL t2_spacing%0d got %0d need 2",
                             i, got1[gb+i].cyc - got1[gb+i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int nacc = 0;
        int k = 0;
        int gb = got1.size();
        int eb = exp1.size();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_op = 3'd0; cmd_a = 32'(i * 7 + 1); cmd_b = 32'd100; cmd_cin = 1'b0;
            cmd_tag = 4'(8 + i);
            cv1 = 1'b1;
            if (cmd_ready1) nacc++;
            @(negedge clk);
            cv1 = 1'b0;
        end
        cmd_op = 3'd1; cmd_a = 32'd50; cmd_b = 32'd7; cmd_tag = 4'd13;
        cv1 = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({nacc == 5, cmd_ready1, count1} !== {2'b10, 3'd4}) begin
            n_fail++;
            $display("FAIL t3_full got acc=%0d rdy=%b cnt=%0d need 5 0 4", nacc, cmd_ready1, count1);
        end
        rsp_ready = 1'b1;
        while (!cmd_ready1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        cv1 = 1'b0;
        wait_got1(gb + 6);
        n_chk++;
        if (got1.size() != gb + 6 || exp1.size() != eb + 6) begin
            n_fail++;
            $display("FAIL t3_count got rsp=%0d acc=%0d need 6 6", got1.size() - gb,
                     exp1.size() - eb);
        end
        for (int i = 0; i < 6 && gb + i < got1.size() && eb + i < exp1.size(); i++) begin
            n_chk++;
            if ({got1[gb+i].res, got1[gb+i].fl, got1[gb+i].tag} !==
                {exp1[eb+i].res, exp1[eb+i].fl, 4'(8 + i)}) begin
                n_fail++;
                $display("FAIL t3_rsp%0d got res=%0h fl=%0h tag=%0d need %0h %0h %0d", i,
                         got1[gb+i].res, got1[gb+i].fl, got1[gb+i].tag,
                         exp1[eb+i].res, exp1[eb+i].fl, 8 + i);
            end
        end
    endtask

    task automatic test_sub;
        int gb = got1.size();
        rsp_ready = 1'b1;
        push1(3'd1, 32'd10, 32'd5, 1'b0, 4'd1);
        push1(3'd1, 32'd5, 32'd10, 1'b0, 4'd2);
        wait_got1(gb + 2);
        n_chk++;
        if (got1.size() != gb + 2) begin
            n_fail++;
            $display("FAIL t4_count got %0d need 2", got1.size() - gb);
        end else begin
            n_chk++;
            if ({got1[gb].res, got1[gb].fl[4]} !== {32'd5, 1'b0}) begin
                n_fail++;
                $display("FAIL t4_pos got res=%0h neg=%b need 5 0", got1[gb].res, got1[gb].fl[4]);
            end
            n_chk++;
            if ({got1[gb+1].res, got1[gb+1].fl[4]} !== {32'hFFFF_FFFB, 1'b1}) begin
                n_fail++;
                $display("FAIL t4_neg got res=%0h neg=%b need fffffffb 1",
                         got1[gb+1].res, got1[gb+1].fl[4]);
            end
        end
    endtask

    task automatic test_shift_reset;
        int gb = got1.size();
        rsp_ready = 1'b1;
        push1(3'd6, 32'd10, 32'd2, 1'b0, 4'd4);
        push1(3'd7, 32'd10, 32'd1, 1'b0, 4'd5);
        wait_got1(gb + 2);
        n_chk++;
        if (got1.size() != gb + 2) begin
            n_fail++;
            $display("FAIL t5_count got %0d need 2", got1.size() - gb);
        end else begin
            n_chk++;
            if ({got1[gb].res, got1[gb+1].res} !== {32'd40, 32'd5}) begin
                n_fail++;
                $display("FAIL t5_shift got sll=%0d srl=%0d need 40 5",
                         got1[gb].res, got1[gb+1].res);
            end
        end
        gb = got1.size();
        push1(3'd0, 32'd1, 32'd1, 1'b0, 4'd6);
        push1(3'd0, 32'd2, 32'd2, 1'b0, 4'd7);
        n_chk++;
        if ({alu_a1, count1, busy1} !== {32'd1, 3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL t5_drive got a=%0d cnt=%0d busy=%b need 1 1 1", alu_a1, count1, busy1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if ({rsp_valid1, count1, busy1, alu_a1} !== '0) begin
            n_fail++;
            $display("FAIL t5_reset got vld=%b cnt=%0d busy=%b a=%0d need 0 0 0 0",
                     rsp_valid1, count1, busy1, alu_a1);
        end
        repeat (8) @(negedge clk);
        n_chk++;
        if (got1.size() != gb || rsp_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_stale got nrsp=%0d vld=%b need 0 0", got1.size() - gb, rsp_valid1);
        end
    endtask

    task automatic test_push_pop;
        int gb = got1.size();
        int eb = exp1.size();
        rsp_ready = 1'b0;
        push1(3'd0, 32'd1, 32'd1, 1'b0, 4'd1);
        push1(3'd0, 32'd2, 32'd2, 1'b0, 4'd2);
        push1(3'd0, 32'd3, 32'd3, 1'b1, 4'd3);
        n_chk++;
        if (count1 !== 3'd2) begin
            n_fail++;
            $display("FAIL t6_pre got cnt=%0d need 2", count1);
        end
        cmd_op = 3'd4; cmd_a = 32'hF0F0; cmd_b = 32'hFF00; cmd_cin = 1'b0; cmd_tag = 4'd4;
        cv1 = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        cv1 = 1'b0;
        n_chk++;
        if (count1 !== 3'd2) begin
            n_fail++;
            $display("FAIL t6_pushpop got cnt=%0d need 2", count1);
        end
        wait_got1(gb + 4);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (gb + i >= got1.size() || eb + i >= exp1.size()) begin
                n_fail++;
                $display("FAIL t6_missing%0d got %0d rsps need 4", i, got1.size() - gb);
            end else if ({got1[gb+i].res, got1[gb+i].tag} !==
                         {exp1[eb+i].res, 4'(i + 1)}) begin
                n_fail++;
                $display("FAIL t6_rsp%0d got res=%0h tag=%0d need %0h %0d", i,
                         got1[gb+i].res, got1[gb+i].tag, exp1[eb+i].res, i + 1);
            end
        end
    endtask

    task automatic test_settle3;
        int lat = 0;
        rsp_ready = 1'b0;
        cmd_op = 3'd0; cmd_a = 32'd6; cmd_b = 32'd2; cmd_cin = 1'b0; cmd_tag = 4'd3;
        cv3 = 1'b1;
        @(negedge clk);
        cv3 = 1'b0;
        while (!rsp_valid3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_chk++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL t6_settle3_latency got %0d need 4", lat);
        end
        n_chk++;
        if ({rsp_result3, rsp_tag3, rsp_flags3} !== {32'd8, 4'd3, fl_fn(3'd0, 32'd6, 32'd2, 1'b0)}) begin
            n_fail++;
            $display("FAIL t6_settle3_rsp got res=%0d tag=%0d fl=%0h need 8 3 %0h",
                     rsp_result3, rsp_tag3, rsp_flags3, fl_fn(3'd0, 32'd6, 32'd2, 1'b0));
        end
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random;
        localparam int N = 40;
        int sent = 0;
        int gb = got1.size();
        int eb = exp1.size();
        for (int c = 0; c < 3000 && sent < N; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                cmd_op  = 3'($urandom_range(0, 7));
                cmd_a   = $urandom;
                cmd_b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                cmd_cin = 1'($urandom_range(0, 1));
                cmd_tag = 4'(sent);
                cv1     = 1'b1;
                if (cmd_ready1) sent++;
            end else begin
                cv1 = 1'b0;
            end
            @(negedge clk);
        end
        cv1 = 1'b0;
        rsp_ready = 1'b1;
        wait_got1(gb + N);
        n_chk++;
        if (got1.size() != gb + N || exp1.size() != eb + N) begin
            n_fail++;
            $display("FAIL rand_count got rsp=%0d acc=%0d need %0d", got1.size() - gb,
                     exp1.size() - eb, N);
        end
        for (int i = 0; i < N && gb + i < got1.size() && eb + i < exp1.size(); i++) begin
            n_chk++;
            if ({got1[gb+i].res, got1[gb+i].fl, got1[gb+i].tag} !==
                {exp1[eb+i].res, exp1[eb+i].fl, exp1[eb+i].tag}) begin
                n_fail++;
                $display("FAIL rand_rsp%0d got res=%0h fl=%0h tag=%0d need %0h %0h %0d", i,
                         got1[gb+i].res, got1[gb+i].fl, got1[gb+i].tag,
                         exp1[eb+i].res, exp1[eb+i].fl, exp1[eb+i].tag);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_burst();
        test_backpressure();
        test_sub();
        test_shift_reset();
        test_push_pop();
        test_settle3();
        test_random();
        n_chk++;
        if (push_to != 0) begin
            n_fail++;
            $display("FAIL push_timeout got %0d stalled pushes need 0", push_to);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion need finish");
        $fatal(1, "watchdog");
    end

endmodule
